// File: rtl/program_end_monitor.sv
// program_end_monitor
//   Watches the CPU program counter for the program-end address. When the
//   address is reached, the monitor halts the CPU and reads N_WORDS result
//   words from data memory. Each word is compared against the expected value,
//   and the outcome is reported as pass or fail. A run-cycle counter bounds
//   the run: if it saturates before the end address is seen, the monitor
//   reports a timeout.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   pc / end_pc  monitored program counter / program-end address
//   base_word    memory word index of result word 0
//   exp_data     expected words, word i at [i*DATA_W +: DATA_W]
//   dmem_rd_en   data-memory read strobe
//   dmem_rd_addr data-memory word address
//   dmem_rd_data read data, valid the cycle after the strobe is sampled
//   cpu_halt     freezes the CPU PC
//   done, pass, fail, timeout  sticky status flags
//   fail_idx     index of the first mismatching word
//   fail_data    value read at fail_idx
//   run_cycles   cycles spent in RUN
module program_end_monitor #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int DMEM_AW = 8,
  parameter int N_WORDS = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PC_W-1:0]           pc,
  input  logic [PC_W-1:0]           end_pc,
  input  logic [DMEM_AW-1:0]        base_word,
  input  logic [N_WORDS*DATA_W-1:0] exp_data,
  output logic                      dmem_rd_en,
  output logic [DMEM_AW-1:0]        dmem_rd_addr,
  input  logic [DATA_W-1:0]         dmem_rd_data,
  output logic                      cpu_halt,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [3:0]                fail_idx,
  output logic [DATA_W-1:0]         fail_data,
  output logic [CNT_W-1:0]          run_cycles
);

  typedef enum logic [1:0] {RUN, READ, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

  state_t              state, state_nxt;
  logic [3:0]          rd_idx, rd_idx_nxt;
  logic                vld_p1, vld_p1_nxt;
  logic [3:0]          cmp_idx_p1, cmp_idx_p1_nxt;
  logic [DATA_W-1:0]   exp_word_p1;

  logic                halt_nxt, rd_en_nxt, done_nxt, pass_nxt, fail_nxt, timeout_nxt;
  logic [DMEM_AW-1:0]  addr_nxt;
  logic [3:0]          fail_idx_nxt;
  logic [DATA_W-1:0]   fail_data_nxt;
  logic [CNT_W-1:0]    run_cycles_nxt;

  assign exp_word_p1 = exp_data[int'(cmp_idx_p1) * DATA_W +: DATA_W];

  always_comb begin
    state_nxt      = state;
    rd_idx_nxt     = rd_idx;
    vld_p1_nxt     = 1'b0;
    cmp_idx_p1_nxt = rd_idx;
    halt_nxt       = cpu_halt;
    rd_en_nxt      = dmem_rd_en;
    addr_nxt       = dmem_rd_addr;
    done_nxt       = done;
    pass_nxt       = pass;
    fail_nxt       = fail;
    timeout_nxt    = timeout;
    fail_idx_nxt   = fail_idx;
    fail_data_nxt  = fail_data;
    run_cycles_nxt = run_cycles;

    case (state)
      RUN: begin
        // End detection takes priority over a coincident timeout.
        if (pc == end_pc) begin
          state_nxt  = READ;
          halt_nxt   = 1'b1;
          rd_en_nxt  = 1'b1;
          addr_nxt   = base_word;
          rd_idx_nxt = 4'd0;
        end else if (&run_cycles) begin
          state_nxt     = DONE;
          halt_nxt      = 1'b1;
          timeout_nxt   = 1'b1;
          fail_nxt      = 1'b1;
          done_nxt      = 1'b1;
          fail_idx_nxt  = 4'd0;
          fail_data_nxt = '0;
        end else begin
          run_cycles_nxt = run_cycles + CNT_W'(1);
        end
      end

      READ: begin
        // Issue stage: the memory samples this strobe now, data returns next cycle.
        if (dmem_rd_en) begin
          vld_p1_nxt     = 1'b1;
          cmp_idx_p1_nxt = rd_idx;
          if (rd_idx == LAST_IDX) begin
            rd_en_nxt = 1'b0;
          end else begin
            rd_idx_nxt = rd_idx + 4'd1;
            addr_nxt   = dmem_rd_addr + DMEM_AW'(1);
          end
        end
        // Compare stage: data for the word issued one edge earlier.
        if (vld_p1) begin
          if (dmem_rd_data != exp_word_p1) begin
            state_nxt     = DONE;
            rd_en_nxt     = 1'b0;
            vld_p1_nxt    = 1'b0;
            fail_nxt      = 1'b1;
            done_nxt      = 1'b1;
            fail_idx_nxt  = cmp_idx_p1;
            fail_data_nxt = dmem_rd_data;
          end else if (cmp_idx_p1 == LAST_IDX) begin
            state_nxt = DONE;
            pass_nxt  = 1'b1;
            done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = DONE;
        halt_nxt  = 1'b1;
        rd_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      rd_idx       <= '0;
      vld_p1       <= 1'b0;
      cpu_halt     <= 1'b0;
      dmem_rd_en   <= 1'b0;
      dmem_rd_addr <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_idx     <= '0;
      fail_data    <= '0;
      run_cycles   <= '0;
    end else begin
      state        <= state_nxt;
      rd_idx       <= rd_idx_nxt;
      vld_p1       <= vld_p1_nxt;
      cpu_halt     <= halt_nxt;
      dmem_rd_en   <= rd_en_nxt;
      dmem_rd_addr <= addr_nxt;
      done         <= done_nxt;
      pass         <= pass_nxt;
      fail         <= fail_nxt;
      timeout      <= timeout_nxt;
      fail_idx     <= fail_idx_nxt;
      fail_data    <= fail_data_nxt;
      run_cycles   <= run_cycles_nxt;
    end
  end

  always_ff @(posedge clk) begin
    cmp_idx_p1 <= cmp_idx_p1_nxt;
  end

endmodule
